// File: rtl/logic_op_pkg.sv
// Shared opcode and FSM state constants for the
// logic-op arbiter and its gate datapath.
package logic_op_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_NOT  = 3'b000;
  localparam opcode_t OP_AND  = 3'b001;
  localparam opcode_t OP_NAND = 3'b010;
  localparam opcode_t OP_OR   = 3'b011;
  localparam opcode_t OP_NOR  = 3'b100;
  localparam opcode_t OP_XOR  = 3'b101;
  localparam opcode_t OP_XNOR = 3'b110;
  localparam opcode_t OP_ILL  = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise gate bank shared by all
// requesters of the arbiter.
module logic_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  opcode_t          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             ill
);

  always_comb begin
    y   = '0;
    ill = 1'b0;
    unique case (op)
      OP_NOT:  y = ~a;
      OP_AND:  y = a & b;
      OP_NAND: y = ~(a & b);
      OP_OR:   y = a | b;
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      OP_ILL:  ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one registered
// logic unit between NREQ requesters.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a,
  input  logic [WIDTH*NREQ-1:0] b,
  output logic [NREQ-1:0]       gnt,
  output logic                  valid,
  output logic [WIDTH-1:0]      result,
  output logic [IDW-1:0]        rid,
  output logic                  err,
  input  logic                  res_ack
);

  logic [1:0]       state;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   sel;
  opcode_t          c_op;
  logic [WIDTH-1:0] c_a;
  logic [WIDTH-1:0] c_b;
  logic [WIDTH-1:0] y;
  logic             ill;

  // Scan downward so the nearest set bit at or
  // after rr_ptr is the last one assigned.
  always_comb begin
    sel = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % NREQ]) begin
        sel = IDW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  logic_unit #(
    .WIDTH (WIDTH)
  ) u_lu (
    .op  (c_op),
    .a   (c_a),
    .b   (c_b),
    .y   (y),
    .ill (ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      win    <= '0;
      c_op   <= OP_NOT;
      c_a    <= '0;
      c_b    <= '0;
      gnt    <= '0;
      valid  <= 1'b0;
      result <= '0;
      rid    <= '0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          gnt <= '0;
          if (|req) begin
            win   <= sel;
            c_op  <= op[3*int'(sel) +: 3];
            c_a   <= a[WIDTH*int'(sel) +: WIDTH];
            c_b   <= b[WIDTH*int'(sel) +: WIDTH];
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << sel;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          gnt    <= '0;
          result <= y;
          err    <= ill;
          rid    <= win;
          valid  <= 1'b1;
          state  <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ack) begin
            valid  <= 1'b0;
            rr_ptr <= (win == IDW'(NREQ - 1)) ? '0
                                              : win + 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: begin
          gnt   <= '0;
          valid <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench: directed scenarios plus random
// traffic against a transaction-level reference model.
module tb_logic_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b1;
  logic [NREQ-1:0]       req = '0;
  logic [3*NREQ-1:0]     op = '0;
  logic [WIDTH*NREQ-1:0] a = '0;
  logic [WIDTH*NREQ-1:0] b = '0;
  logic [NREQ-1:0]       gnt;
  logic                  valid;
  logic [WIDTH-1:0]      result;
  logic [IDW-1:0]        rid;
  logic                  err;
  logic                  res_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  logic_op_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .op      (op),
    .a       (a),
    .b       (b),
    .gnt     (gnt),
    .valid   (valid),
    .result  (result),
    .rid     (rid),
    .err     (err),
    .res_ack (res_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is "age" cycles old
  // (0 none, 1 granted, 2 result on offer).
  int               m_age;
  int               m_ptr;
  int               m_w;
  logic [2:0]       m_op;
  logic [WIDTH-1:0] m_a;
  logic [WIDTH-1:0] m_b;
  logic [NREQ-1:0]  m_gnt;
  logic             m_valid;
  logic [WIDTH-1:0] m_res;
  logic [IDW-1:0]   m_rid;
  logic             m_err;

  function automatic logic [WIDTH:0] ref_logic(
    input logic [2:0] o,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] z);
    logic [WIDTH-1:0] ones;
    ones = '1;
    case (o)
      3'd0: return {1'b0, ones ^ x};
      3'd1: return {1'b0, x & z};
      3'd2: return {1'b0, ones ^ (x & z)};
      3'd3: return {1'b0, x | z};
      3'd4: return {1'b0, ones ^ (x | z)};
      3'd5: return {1'b0, x ^ z};
      3'd6: return {1'b0, ones ^ x ^ z};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  task automatic model_reset();
    m_age = 0;
    m_ptr = 0;
    m_w = 0;
    m_gnt = '0;
    m_valid = 1'b0;
    m_res = '0;
    m_rid = '0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [WIDTH:0] r;
    if (m_age == 0) begin
      m_gnt = '0;
      for (int k = 0; k < NREQ; k++) begin
        if (m_age == 0 && req[(m_ptr + k) % NREQ]) begin
          m_w = (m_ptr + k) % NREQ;
          m_op = op[3*m_w +: 3];
          m_a = a[WIDTH*m_w +: WIDTH];
          m_b = b[WIDTH*m_w +: WIDTH];
          m_gnt = NREQ'(1) << m_w;
          m_age = 1;
        end
      end
    end else if (m_age == 1) begin
      r = ref_logic(m_op, m_a, m_b);
      m_gnt = '0;
      m_valid = 1'b1;
      m_res = r[WIDTH-1:0];
      m_err = r[WIDTH];
      m_rid = IDW'(m_w);
      m_age = 2;
    end else if (res_ack) begin
      m_valid = 1'b0;
      m_ptr = (m_w + 1) % NREQ;
      m_age = 0;
    end
  endtask

  // One clock: model sees the same inputs as the DUT,
  // outputs compared 1 time unit after the edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check("gnt", gnt, m_gnt);
    check("valid", valid, m_valid);
    if (m_valid) begin
      check("result", result, m_res);
      check("rid", rid, m_rid);
      check("err", err, m_err);
    end
  endtask

  task automatic put(input int i, input logic [2:0] o,
                     input logic [WIDTH-1:0] x,
                     input logic [WIDTH-1:0] z);
    op[3*i +: 3] = o;
    a[WIDTH*i +: WIDTH] = x;
    b[WIDTH*i +: WIDTH] = z;
  endtask

  logic [WIDTH-1:0] exp_tab [8];
  int g_cyc [$];
  int g_id [$];
  int seen;

  initial begin
    exp_tab = '{8'h5A, 8'h05, 8'hFA, 8'hAF,
                8'h50, 8'hAA, 8'h55, 8'h00};
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    check("rst_gnt", gnt, 0);
    check("rst_valid", valid, 0);
    check("rst_result", result, 0);
    check("rst_rid", rid, 0);
    check("rst_err", err, 0);
    cycle();
    rst_n = 1'b1;

    // single request
    req = 4'b0001;
    put(0, 3'b001, 8'hF0, 8'h3C);
    res_ack = 1'b1;
    cycle();
    check("t1_gnt", gnt, 4'b0001);
    req = '0;
    put(0, 3'b111, 8'h00, 8'h00);
    cycle();
    check("t1_valid", valid, 1);
    check("t1_result", result, 8'h30);
    check("t1_rid", rid, 0);
    check("t1_err", err, 0);
    cycle();
    check("t1_valid_low", valid, 0);

    // every opcode on requester 2
    for (int o = 0; o < 8; o++) begin
      req = 4'b0100;
      put(2, 3'(o), 8'hA5, 8'h0F);
      cycle();
      check("op_gnt", gnt, 4'b0100);
      req = '0;
      cycle();
      check($sformatf("op%0d_result", o), result, exp_tab[o]);
      check($sformatf("op%0d_err", o), err, (o == 7) ? 1 : 0);
      check("op_rid", rid, 2);
      cycle();
    end

    // wrap from rr_ptr=3, then withdrawal of requester 1
    req = 4'b1001;
    put(3, 3'b011, 8'h11, 8'h22);
    put(0, 3'b101, 8'hFF, 8'h0F);
    cycle();
    check("wrap_gnt3", gnt, 4'b1000);
    cycle();
    check("wrap_rid3", rid, 3);
    check("wrap_res3", result, 8'h33);
    cycle();
    cycle();
    check("wrap_gnt0", gnt, 4'b0001);
    req = 4'b0010;
    cycle();
    check("wrap_res0", result, 8'hF0);
    req = '0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      seen += int'(gnt[1]) + int'(valid);
    end
    check("withdraw", seen, 0);

    // back-pressure
    req = 4'b0001;
    put(0, 3'b101, 8'h3C, 8'hFF);
    res_ack = 1'b0;
    cycle();
    check("bp_gnt", gnt, 4'b0001);
    req = 4'b0100;
    put(0, 3'b000, 8'h00, 8'h00);
    put(2, 3'b001, 8'hFF, 8'h81);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_valid", valid, 1);
      check("bp_result", result, 8'hC3);
      check("bp_rid", rid, 0);
      check("bp_gnt_hold", gnt, 0);
    end
    res_ack = 1'b1;
    cycle();
    check("bp_release", valid, 0);
    check("bp_no_gnt", gnt, 0);
    cycle();
    check("bp_gnt2", gnt, 4'b0100);
    req = '0;
    cycle();
    check("bp_res2", result, 8'h81);
    cycle();

    // asynchronous reset while the result is on offer
    req = 4'b0010;
    res_ack = 1'b0;
    cycle();
    req = '0;
    cycle();
    check("mid_valid_pre", valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid", valid, 0);
    check("mid_gnt", gnt, 0);
    check("mid_result", result, 0);
    check("mid_rid", rid, 0);
    check("mid_err", err, 0);
    model_reset();
    cycle();
    rst_n = 1'b1;
    req = 4'b1001;
    res_ack = 1'b1;
    cycle();
    check("mid_after_gnt", gnt, 4'b0001);
    req = '0;
    cycle();
    cycle();

    // fairness from reset with all requesters asserted
    rst_n = 1'b0;
    #1;
    model_reset();
    cycle();
    rst_n = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < NREQ; r++)
        put(r, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom));
      cycle();
      for (int r = 0; r < NREQ; r++) begin
        if (gnt[r]) begin
          g_cyc.push_back(i);
          g_id.push_back(r);
        end
      end
    end
    check("fair_cnt", (g_id.size() >= 5) ? 1 : 0, 1);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      check("fair_id", g_id[k], k % NREQ);
      if (k > 0)
        check("fair_gap", g_cyc[k] - g_cyc[k-1], 3);
    end

    // random traffic
    for (int i = 0; i < 600; i++) begin
      req = NREQ'($urandom);
      res_ack = ($urandom_range(0, 3) != 0);
      for (int r = 0; r < NREQ; r++)
        put(r, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom));
      cycle();
    end
    req = '0;
    res_ack = 1'b1;
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
